otp_zeroize_seq: RTL and testbench

- Parametrised OCP-lock zeroization sequencer for fuse_ctrl.
- Zeroizes a contiguous run of scrambled-block-sized OTP regions through a single-outstanding macro command port.
- Reads each block back, popcounts it against a valid bound and a fatal bound, and retries marginal blocks a configurable number of times.
- Sits between the DAI and the OTP macro arbiter; replaces single-word zeroize checks with a multi-block, retrying engine.

---
 rtl/otp_zeroize_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_otp_zeroize_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_zeroize_seq.sv
// otp_zeroize_seq
// Multi-block OTP zeroization engine for fuse_ctrl (OCP-lock). It zeroizes
// a contiguous run of scrambled-block-sized regions and reads each block
// back. It popcounts the block against a valid bound and a fatal bound, and
// it re-zeroizes marginal blocks up to MaxRetries extra times. At most one
// macro command is outstanding at any time.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start pulse (sampled only in IDLE)
//   base_addr_i             native-word address of block 0
//   num_blocks_i            number of blocks to zeroize
//   busy_o                  high in every state except IDLE
//   done_o                  one-cycle completion pulse (success or error)
//   err_o                   otp_err_e code of the last run
//   fatal_o                 sticky fatal flag, cleared only by reset
//   marginal_cnt_o          blocks accepted as marginal (saturating)
//   fail_addr_o             block address that caused the error
//   otp_req_o/otp_zeroize_o/otp_addr_o   macro command (held until grant)
//   otp_gnt_i               command accepted
//   otp_rvalid_i/otp_rdata_i/otp_err_i   macro response
module otp_zeroize_seq #(
  parameter int OtpWidth   = 16,
  parameter int BeatWidth  = 32,
  parameter int BlockWidth = 64,
  parameter int AddrWidth  = 13,
  parameter int CntWidth   = 8,
  parameter int ValidBound = BlockWidth - 8,
  parameter int FatalBound = (BlockWidth / 4) * 3,
  parameter int MaxRetries = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_blocks_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           err_o,
  output logic                 fatal_o,
  output logic [CntWidth-1:0]  marginal_cnt_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic                 otp_req_o,
  output logic                 otp_zeroize_o,
  output logic [AddrWidth-1:0] otp_addr_o,
  input  logic                 otp_gnt_i,
  input  logic                 otp_rvalid_i,
  input  logic [BeatWidth-1:0] otp_rdata_i,
  input  logic [2:0]           otp_err_i
);

  localparam int Wpb      = BlockWidth / OtpWidth;
  localparam int Bpb      = BlockWidth / BeatWidth;
  localparam int AccW     = $clog2(BlockWidth + 1);
  localparam int BeatIdxW = (Bpb > 1) ? $clog2(Bpb) : 1;
  localparam int RetryW   = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int ChkW     = AddrWidth + CntWidth + 1;

  localparam logic [AddrWidth-1:0] WpbA     = AddrWidth'(Wpb);
  localparam logic [AddrWidth-1:0] BeatStep = AddrWidth'(BeatWidth / OtpWidth);
  localparam logic [AccW-1:0]      ValidB   = AccW'(ValidBound);
  localparam logic [AccW-1:0]      FatalB   = AccW'(FatalBound);
  localparam logic [BeatIdxW-1:0]  BeatLast = BeatIdxW'(Bpb - 1);
  localparam logic [RetryW-1:0]    MaxR     = RetryW'(MaxRetries);
  localparam logic [ChkW-1:0]      AddrLim  = ChkW'(1) << AddrWidth;

  localparam logic [2:0] NoError        = 3'd0;
  localparam logic [2:0] MacroError     = 3'd1;
  localparam logic [2:0] MacroEccCorr   = 3'd2;
  localparam logic [2:0] MacroEccUncorr = 3'd3;
  localparam logic [2:0] AccessError    = 3'd5;
  localparam logic [2:0] CheckFailError = 3'd6;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ZREQ  = 3'd1;
  localparam logic [2:0] S_ZWAIT = 3'd2;
  localparam logic [2:0] S_RREQ  = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  function automatic logic [AccW-1:0] popcnt(input logic [BeatWidth-1:0] d);
    logic [AccW-1:0] c;
    c = '0;
    for (int i = 0; i < BeatWidth; i++) c = c + AccW'(d[i]);
    return c;
  endfunction

  // Control state (reset)
  logic [2:0]           state_q, state_d;
  logic                 req_q, req_d;
  logic                 zero_q, zero_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 done_q, done_d;
  logic [2:0]           err_q, err_d;
  logic                 fatal_q, fatal_d;
  logic [CntWidth-1:0]  mcnt_q, mcnt_d;
  logic [AddrWidth-1:0] fail_q, fail_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  // Run bookkeeping (always initialised on start, so not reset)
  logic [CntWidth-1:0]  blk_q, blk_d;
  logic [CntWidth-1:0]  num_q, num_d;
  logic [AddrWidth-1:0] blk_addr_q, blk_addr_d;
  logic [BeatIdxW-1:0]  beat_q, beat_d;
  logic [AccW-1:0]      acc_q, acc_d;

  logic [ChkW-1:0]      end_addr;
  logic                 pass;

  // Range check is done wide enough that base + num*WPB cannot wrap.
  assign end_addr = ChkW'(base_addr_i) + ChkW'(num_blocks_i) * ChkW'(Wpb);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    zero_d     = zero_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    err_d      = err_q;
    fatal_d    = fatal_q;
    mcnt_d     = mcnt_q;
    fail_d     = fail_q;
    retry_d    = retry_q;
    blk_d      = blk_q;
    num_d      = num_q;
    blk_addr_d = blk_addr_q;
    beat_d     = beat_q;
    acc_d      = acc_q;
    pass       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcnt_d     = '0;
          err_d      = NoError;
          fail_d     = '0;
          blk_d      = '0;
          retry_d    = '0;
          beat_d     = '0;
          acc_d      = '0;
          num_d      = num_blocks_i;
          blk_addr_d = base_addr_i;
          if (num_blocks_i == '0 || end_addr > AddrLim) begin
            err_d   = AccessError;
            fail_d  = base_addr_i;
            done_d  = 1'b1;
            state_d = S_ERR;
          end else begin
            req_d   = 1'b1;
            zero_d  = 1'b1;
            addr_d  = base_addr_i;
            state_d = S_ZREQ;
          end
        end
      end
      S_ZREQ, S_RREQ: begin
        if (otp_gnt_i) begin
          req_d   = 1'b0;
          state_d = (state_q == S_ZREQ) ? S_ZWAIT : S_RWAIT;
        end
      end
      S_ZWAIT: begin
        if (otp_rvalid_i) begin
          if (otp_err_i == NoError) begin
            beat_d  = '0;
            req_d   = 1'b1;
            zero_d  = 1'b0;
            addr_d  = blk_addr_q;
            state_d = S_RREQ;
          end else begin
            err_d   = MacroError;
            fail_d  = blk_addr_q;
            done_d  = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_RWAIT: begin
        if (otp_rvalid_i) begin
          // ECC status is meaningless on zeroized words; only hard errors abort.
          if (otp_err_i == NoError || otp_err_i == MacroEccCorr ||
              otp_err_i == MacroEccUncorr) begin
            acc_d = acc_q + popcnt(otp_rdata_i);
            if (beat_q != BeatLast) begin
              beat_d  = beat_q + BeatIdxW'(1);
              req_d   = 1'b1;
              addr_d  = addr_q + BeatStep;
              state_d = S_RREQ;
            end else begin
              state_d = S_CHECK;
            end
          end else begin
            err_d   = MacroError;
            fail_d  = blk_addr_q;
            done_d  = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_CHECK: begin
        // Accumulator restarts for every attempt, retried or not.
        acc_d = '0;
        if (acc_q >= ValidB) begin
          pass = 1'b1;
        end else if (acc_q < FatalB) begin
          err_d   = CheckFailError;
          fatal_d = 1'b1;
          fail_d  = blk_addr_q;
          done_d  = 1'b1;
          state_d = S_ERR;
        end else if (retry_q < MaxR) begin
          retry_d = retry_q + RetryW'(1);
          req_d   = 1'b1;
          zero_d  = 1'b1;
          addr_d  = blk_addr_q;
          state_d = S_ZREQ;
        end else begin
          pass = 1'b1;
          if (mcnt_q != {CntWidth{1'b1}}) mcnt_d = mcnt_q + CntWidth'(1);
        end
        if (pass) begin
          retry_d = '0;
          if (blk_q == num_q - CntWidth'(1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            blk_d      = blk_q + CntWidth'(1);
            blk_addr_d = blk_addr_q + WpbA;
            req_d      = 1'b1;
            zero_d     = 1'b1;
            addr_d     = blk_addr_q + WpbA;
            state_d    = S_ZREQ;
          end
        end
      end
      default: begin  // S_DONE, S_ERR: done_o is high this cycle
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      zero_q  <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= NoError;
      fatal_q <= 1'b0;
      mcnt_q  <= '0;
      fail_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      zero_q  <= zero_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fatal_q <= fatal_d;
      mcnt_q  <= mcnt_d;
      fail_q  <= fail_d;
      retry_q <= retry_d;
    end
  end

  // Run bookkeeping registers
  always_ff @(posedge clk_i) begin
    blk_q      <= blk_d;
    num_q      <= num_d;
    blk_addr_q <= blk_addr_d;
    beat_q     <= beat_d;
    acc_q      <= acc_d;
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign fatal_o        = fatal_q;
  assign marginal_cnt_o = mcnt_q;
  assign fail_addr_o    = fail_q;
  assign otp_req_o      = req_q;
  assign otp_zeroize_o  = zero_q;
  assign otp_addr_o     = addr_q;

endmodule

// File: tb/tb_otp_zeroize_seq.sv
// Directed bench for otp_zeroize_seq with default parameters
// (16-bit words, 32-bit beats, 64-bit blocks, bounds 56/48, 2 retries).
module tb_otp_zeroize_seq;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [12:0] base_addr_i;
  logic [7:0]  num_blocks_i;
  logic        busy_o, done_o, fatal_o;
  logic [2:0]  err_o;
  logic [7:0]  marginal_cnt_o;
  logic [12:0] fail_addr_o;
  logic        otp_req_o, otp_zeroize_o;
  logic [12:0] otp_addr_o;
  logic        otp_gnt_i, otp_rvalid_i;
  logic [31:0] otp_rdata_i;
  logic [2:0]  otp_err_i;

  otp_zeroize_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_blocks_i(num_blocks_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .fatal_o(fatal_o),
    .marginal_cnt_o(marginal_cnt_o), .fail_addr_o(fail_addr_o),
    .otp_req_o(otp_req_o), .otp_zeroize_o(otp_zeroize_o), .otp_addr_o(otp_addr_o),
    .otp_gnt_i(otp_gnt_i), .otp_rvalid_i(otp_rvalid_i),
    .otp_rdata_i(otp_rdata_i), .otp_err_i(otp_err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Macro model configuration and request log
  int          gnt_delay = 0;
  logic [31:0] rd_q[$];
  logic [2:0]  rderr_q[$];
  logic [2:0]  zerr_q[$];
  logic        log_zero[$];
  logic [12:0] log_addr[$];
  int          done_cyc;

  localparam logic [31:0] Ones32 = 32'hFFFF_FFFF;
  localparam logic [31:0] Ones20 = 32'h000F_FFFF;  // 32+20 = 52 ones: marginal
  localparam logic [31:0] Ones28 = 32'h0FFF_FFFF;  // 32+28 = 60 ones: valid
  localparam logic [31:0] Ones8  = 32'h0000_00FF;  // 32+8  = 40 ones: fatal

  task automatic kick(input logic [12:0] base, input logic [7:0] n);
    @(negedge clk_i);
    log_zero.delete();
    log_addr.delete();
    base_addr_i  = base;
    num_blocks_i = n;
    start_i      = 1'b1;
  endtask

  // Acts as the OTP macro: grants after gnt_delay waiting cycles, responds
  // one cycle after the grant, and stops at the first done_o pulse.
  task automatic run_macro(input int limit);
    int          wait_cnt;
    bit          pend, pend_zero, hold_valid;
    logic [12:0] hold_addr;
    logic        hold_zero;
    wait_cnt = 0; pend = 0; pend_zero = 0; hold_valid = 0;
    hold_addr = '0; hold_zero = 1'b0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0; otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0;
      otp_err_i = 3'd0; otp_rdata_i = '0;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (pend) begin
        otp_rvalid_i = 1'b1;
        if (pend_zero) begin
          if (zerr_q.size() > 0) otp_err_i = zerr_q.pop_front();
        end else begin
          otp_rdata_i = Ones32;
          if (rd_q.size() > 0) otp_rdata_i = rd_q.pop_front();
          if (rderr_q.size() > 0) otp_err_i = rderr_q.pop_front();
        end
        pend = 0;
      end
      if (otp_req_o) begin
        if (hold_valid) begin
          checks++;
          if (otp_addr_o !== hold_addr || otp_zeroize_o !== hold_zero) begin
            errors++;
            $display("FAIL req_hold: addr=%h zero=%b, required addr=%h zero=%b",
                     otp_addr_o, otp_zeroize_o, hold_addr, hold_zero);
          end
        end else begin
          hold_valid = 1; hold_addr = otp_addr_o; hold_zero = otp_zeroize_o;
        end
        if (wait_cnt >= gnt_delay) begin
          otp_gnt_i = 1'b1;
          log_zero.push_back(otp_zeroize_o);
          log_addr.push_back(otp_addr_o);
          pend = 1; pend_zero = otp_zeroize_o;
          wait_cnt = 0; hold_valid = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: no done_o within %0d cycles", limit);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if ({busy_o, done_o, err_o, fatal_o, marginal_cnt_o, fail_addr_o,
         otp_req_o, otp_zeroize_o, otp_addr_o} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%0d fatal=%b marg=%0d fail=%h req=%b, required all 0",
               busy_o, done_o, err_o, fatal_o, marginal_cnt_o, fail_addr_o, otp_req_o);
    end
  endtask

  task automatic test_good_run;
    logic [12:0] exp_a [9] = '{13'h100, 13'h100, 13'h102, 13'h104, 13'h104,
                               13'h106, 13'h108, 13'h108, 13'h10A};
    logic        exp_z [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    kick(13'h100, 8'd3);
    run_macro(100);
    checks++;
    if (log_addr.size() != 9) begin
      errors++;
      $display("FAIL good_req_count: got %0d, required 9", log_addr.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (log_addr[i] !== exp_a[i] || log_zero[i] !== exp_z[i]) begin
          errors++;
          $display("FAIL good_req%0d: addr=%h zero=%b, required addr=%h zero=%b",
                   i, log_addr[i], log_zero[i], exp_a[i], exp_z[i]);
        end
      end
    end
    checks++;
    if (done_cyc != 22) begin
      errors++;
      $display("FAIL good_latency: got %0d cycles, required 22", done_cyc);
    end
    checks++;
    if (err_o !== 3'd0 || marginal_cnt_o !== 8'd0 || fatal_o !== 1'b0) begin
      errors++;
      $display("FAIL good_status: err=%0d marg=%0d fatal=%b, required 0/0/0",
               err_o, marginal_cnt_o, fatal_o);
    end
  endtask

  task automatic test_marginal_retry;
    int nz;
    rd_q = '{Ones32, Ones20, Ones32, Ones20, Ones32, Ones28};
    kick(13'h200, 8'd1);
    run_macro(100);
    nz = 0;
    foreach (log_zero[i]) if (log_zero[i] && log_addr[i] == 13'h200) nz++;
    checks++;
    if (nz != 3 || log_zero.size() != 9) begin
      errors++;
      $display("FAIL retry_zeroizes: got %0d zeroize of %0d reqs, required 3 of 9",
               nz, log_zero.size());
    end
    checks++;
    if (err_o !== 3'd0 || marginal_cnt_o !== 8'd0 || done_cyc != 22) begin
      errors++;
      $display("FAIL retry_status: err=%0d marg=%0d cyc=%0d, required 0/0/22",
               err_o, marginal_cnt_o, done_cyc);
    end
  endtask

  task automatic test_marginal_exhausted;
    int nz;
    rd_q = '{Ones32, Ones20, Ones32, Ones20, Ones32, Ones20};
    kick(13'h300, 8'd1);
    run_macro(100);
    nz = 0;
    foreach (log_zero[i]) if (log_zero[i]) nz++;
    checks++;
    if (nz != 3) begin
      errors++;
      $display("FAIL exhaust_zeroizes: got %0d, required 3", nz);
    end
    checks++;
    if (err_o !== 3'd0 || marginal_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL exhaust_status: err=%0d marg=%0d, required 0/1", err_o, marginal_cnt_o);
    end
  endtask

  task automatic test_macro_errors;
    // Zeroize response error
    zerr_q = '{3'd1};
    kick(13'h500, 8'd2);
    run_macro(100);
    checks++;
    if (err_o !== 3'd1 || fail_addr_o !== 13'h500 || log_addr.size() != 1) begin
      errors++;
      $display("FAIL zeroize_err: err=%0d fail=%h reqs=%0d, required 1/500/1",
               err_o, fail_addr_o, log_addr.size());
    end
    // Uncorrectable ECC on a read is tolerated
    rderr_q = '{3'd3};
    kick(13'h600, 8'd1);
    run_macro(100);
    checks++;
    if (err_o !== 3'd0 || log_addr.size() != 3 || marginal_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL ecc_ignored: err=%0d reqs=%0d marg=%0d, required 0/3/0",
               err_o, log_addr.size(), marginal_cnt_o);
    end
    // Zero blocks
    kick(13'h700, 8'd0);
    run_macro(20);
    checks++;
    if (err_o !== 3'd5 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL zero_blocks: err=%0d reqs=%0d, required 5/0", err_o, log_addr.size());
    end
    // Run past the top of the address space
    kick(13'h1FFC, 8'd2);
    run_macro(20);
    checks++;
    if (err_o !== 3'd5 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL range_over: err=%0d reqs=%0d, required 5/0", err_o, log_addr.size());
    end
    // Ending exactly at the top is legal
    kick(13'h1FFC, 8'd1);
    run_macro(100);
    checks++;
    if (err_o !== 3'd0 || log_addr.size() != 3 || log_addr[2] !== 13'h1FFE) begin
      errors++;
      $display("FAIL range_edge: err=%0d reqs=%0d, required 0/3 last 1ffe", err_o, log_addr.size());
    end
  endtask

  task automatic test_handshake_delay;
    gnt_delay = 5;
    kick(13'h800, 8'd1);
    run_macro(200);
    gnt_delay = 0;
    checks++;
    if (log_addr.size() != 3 || log_addr[0] !== 13'h800 || log_addr[2] !== 13'h802) begin
      errors++;
      $display("FAIL delay_reqs: count=%0d, required 3 at 800,800,802", log_addr.size());
    end
    checks++;
    if (done_cyc != 23 || err_o !== 3'd0) begin
      errors++;
      $display("FAIL delay_latency: cyc=%0d err=%0d, required 23/0", done_cyc, err_o);
    end
  endtask

  task automatic test_fatal;
    rd_q = '{Ones32, Ones32, Ones32, Ones8};
    kick(13'h400, 8'd3);
    run_macro(100);
    checks++;
    if (err_o !== 3'd6 || fatal_o !== 1'b1 || fail_addr_o !== 13'h404) begin
      errors++;
      $display("FAIL fatal_status: err=%0d fatal=%b fail=%h, required 6/1/404",
               err_o, fatal_o, fail_addr_o);
    end
    repeat (4) @(negedge clk_i);
    checks++;
    if (otp_req_o !== 1'b0 || log_addr.size() != 6 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL fatal_stop: req=%b reqs=%0d busy=%b, required 0/6/0",
               otp_req_o, log_addr.size(), busy_o);
    end
    // A later clean run leaves the fatal flag set
    kick(13'hA00, 8'd1);
    run_macro(100);
    checks++;
    if (err_o !== 3'd0 || fatal_o !== 1'b1) begin
      errors++;
      $display("FAIL fatal_sticky: err=%0d fatal=%b, required 0/1", err_o, fatal_o);
    end
  endtask

  task automatic test_reset_midrun;
    kick(13'h900, 8'd1);
    @(negedge clk_i); start_i = 1'b0;          // ZREQ
    otp_gnt_i = 1'b1;
    @(negedge clk_i); otp_gnt_i = 1'b0;        // ZWAIT
    otp_rvalid_i = 1'b1; otp_err_i = 3'd0;
    @(negedge clk_i); otp_rvalid_i = 1'b0;     // RREQ
    otp_gnt_i = 1'b1;
    @(negedge clk_i); otp_gnt_i = 1'b0;        // RWAIT
    checks++;
    if (busy_o !== 1'b1 || otp_req_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_state: busy=%b req=%b, required 1/0", busy_o, otp_req_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    checks++;
    if ({busy_o, done_o, err_o, fatal_o, marginal_cnt_o, fail_addr_o,
         otp_req_o, otp_zeroize_o, otp_addr_o} !== 42'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b err=%0d fatal=%b req=%b addr=%h, required all 0",
               busy_o, done_o, err_o, fatal_o, otp_req_o, otp_addr_o);
    end
    otp_rvalid_i = 1'b1; otp_rdata_i = Ones32;
    @(negedge clk_i); otp_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || otp_req_o !== 1'b0 || err_o !== 3'd0) begin
      errors++;
      $display("FAIL late_rvalid: busy=%b done=%b req=%b err=%0d, required 0/0/0/0",
               busy_o, done_o, otp_req_o, err_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_blocks_i = '0;
    otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_rdata_i = '0; otp_err_i = '0;
    test_reset();
    test_good_run();
    test_marginal_retry();
    test_marginal_exhausted();
    test_macro_errors();
    test_handshake_delay();
    test_fatal();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
